// File: rtl/memory_access_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// memory_access_if
// Data-memory request/acknowledge bus between the memory_access stage and the
// data memory.
//   req    master->slave  request, held until ack
//   we     master->slave  1 = store, 0 = load
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  store data, lane-replicated
//   wstrb  master->slave  byte strobes for stores
//   rdata  slave->master  load word
//   ack    slave->master  completes the request
// -----------------------------------------------------------------------------
interface memory_access_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wstrb;
  logic [XLEN-1:0] rdata;
  logic            ack;

  // Pipeline-stage side.
  modport master (
    output req, we, addr, wdata, wstrb,
    input  rdata, ack
  );

  // Memory side.
  modport slave (
    input  req, we, addr, wdata, wstrb,
    output rdata, ack
  );
endinterface

// File: rtl/memory_access.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// memory_access
// Memory stage of the multicycle RV32I core. Takes one instruction from
// execute, performs its load/store over the dmem req/ack bus, formats load
// data and hands the result to write-back. Non-memory ops pass through with
// one cycle of latency.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   startSig                 one-cycle kick out of IDLE
//   beforePipReadyToSend     execute holds a valid instruction
//   nextPipReadyToRcv        write-back can take the held instruction
//   ex_*                     instruction payload from execute
//   curPipReadyToRcv         ex_* are sampled this cycle
//   curPipReadyToSend        result valid toward write-back
//   wb_valid/idx/val         write-back payload
//   wb_en_valid/idx/data     write-back register load enables (transfer pulse)
//   bp_idx, bp_val           bypass toward decode, 0 unless forwarding
//   dmem                     data memory bus (memory_access_if.master)
//   misalign                 misaligned access being held in SENDING
//
// Build option
//   MEM_MISALIGN_CHECK_EN    when defined, misaligned H/W accesses skip the
//                            memory, report misalign and suppress wb_valid.
//                            When undefined, misalign is tied 0 and the
//                            address is aligned down to the access size.
// -----------------------------------------------------------------------------
module memory_access #(
  parameter int XLEN    = 32,
  parameter int REG_IDX = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startSig,
  input  logic               beforePipReadyToSend,
  input  logic               nextPipReadyToRcv,
  input  logic               ex_valid,
  input  logic [REG_IDX-1:0] ex_idx,
  input  logic [XLEN-1:0]    ex_val,
  input  logic [XLEN-1:0]    ex_store_data,
  input  logic               ex_is_load,
  input  logic               ex_is_store,
  input  logic [2:0]         ex_funct3,
  output logic               curPipReadyToRcv,
  output logic               curPipReadyToSend,
  output logic               wb_valid,
  output logic [REG_IDX-1:0] wb_idx,
  output logic [XLEN-1:0]    wb_val,
  output logic               wb_en_valid,
  output logic               wb_en_idx,
  output logic               wb_en_data,
  output logic [REG_IDX-1:0] bp_idx,
  output logic [XLEN-1:0]    bp_val,
  memory_access_if.master    dmem,
  output logic               misalign
);

  typedef enum logic [1:0] {IDLE, WAIT_BEF, MEM_REQ, SENDING} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t             state;
  logic               valid_q;
  logic [REG_IDX-1:0] idx_q;
  logic [XLEN-1:0]    val_q;
  logic [XLEN-1:0]    sdata_q;
  logic               is_load_q;
  logic               is_store_q;
  logic [2:0]         funct3_q;
  logic [XLEN-1:0]    rdata_q;
`ifdef MEM_MISALIGN_CHECK_EN
  logic               misalign_q;
`endif

  // Access size. Stores only know SB/SH/SW; loads add the unsigned forms.
  // Anything unlisted behaves as a word access.
  function automatic logic [1:0] size_of(input logic is_store, input logic [2:0] f3);
    logic [1:0] sz;
    sz = SZ_W;
    if (f3 == 3'b000 || (!is_store && f3 == 3'b100))      sz = SZ_B;
    else if (f3 == 3'b001 || (!is_store && f3 == 3'b101)) sz = SZ_H;
    return sz;
  endfunction

  logic accept;
  logic in_mem;
  logic in_send;
  logic go_mem;

  assign in_mem            = (state == MEM_REQ);
  assign in_send           = (state == SENDING);
  assign curPipReadyToRcv  = (state == WAIT_BEF) | (in_send & nextPipReadyToRcv);
  assign curPipReadyToSend = in_send;
  assign accept            = curPipReadyToRcv & beforePipReadyToSend;

`ifdef MEM_MISALIGN_CHECK_EN
  // A misaligned half/word access is routed straight to SENDING.
  logic misalign_in;
  always_comb begin
    misalign_in = 1'b0;
    if (ex_is_load | ex_is_store) begin
      case (size_of(ex_is_store, ex_funct3))
        SZ_H:    misalign_in = ex_val[0];
        SZ_W:    misalign_in = |ex_val[1:0];
        default: misalign_in = 1'b0;
      endcase
    end
  end
  assign go_mem   = (ex_is_load | ex_is_store) & ~misalign_in;
  assign misalign = misalign_q & in_send;
`else
  assign go_mem   = ex_is_load | ex_is_store;
  assign misalign = 1'b0;
`endif

  // Stage FSM and payload latches. An accept can happen from WAIT_BEF or
  // from SENDING when write-back takes the current result in the same cycle,
  // so it is handled ahead of the per-state moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      val_q      <= '0;
      sdata_q    <= '0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      rdata_q    <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else if (accept) begin
      valid_q    <= ex_valid;
      idx_q      <= ex_idx;
      val_q      <= ex_val;
      sdata_q    <= ex_store_data;
      is_load_q  <= ex_is_load;
      is_store_q <= ex_is_store;
      funct3_q   <= ex_funct3;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_q <= misalign_in;
`endif
      state      <= go_mem ? MEM_REQ : SENDING;
    end else begin
      case (state)
        IDLE:     if (startSig) state <= WAIT_BEF;
        MEM_REQ:  if (dmem.ack) begin
                    rdata_q <= dmem.rdata;
                    state   <= SENDING;
                  end
        SENDING:  if (nextPipReadyToRcv) state <= WAIT_BEF;
        default:  state <= state;
      endcase
    end
  end

  // Store lane formatting from the latched instruction.
  logic [1:0]      st_size;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wstrb;
  always_comb begin
    st_size  = size_of(1'b1, funct3_q);
    st_wdata = sdata_q;
    st_wstrb = 4'b1111;
    case (st_size)
      SZ_B: begin
        st_wdata = {4{sdata_q[7:0]}};
        st_wstrb = 4'b0001 << val_q[1:0];
      end
      SZ_H: begin
        st_wdata = {2{sdata_q[15:0]}};
        st_wstrb = 4'b0011 << {val_q[1], 1'b0};
      end
      default: ;
    endcase
  end

  // The bus is driven only in MEM_REQ so it reads 0 in every other state.
  assign dmem.req   = in_mem;
  assign dmem.we    = in_mem & is_store_q;
  assign dmem.addr  = in_mem ? {val_q[XLEN-1:2], 2'b00} : '0;
  assign dmem.wdata = (in_mem & is_store_q) ? st_wdata : '0;
  assign dmem.wstrb = (in_mem & is_store_q) ? st_wstrb : 4'b0000;

  // Load formatting: pick the lane by the low address bits, then extend.
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_val;
  always_comb begin
    case (val_q[1:0])
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = val_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (funct3_q)
      3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_val = rdata_q;
    endcase
  end

  // Write-back payload, transfer pulses and bypass.
`ifdef MEM_MISALIGN_CHECK_EN
  assign wb_valid = valid_q & ~is_store_q & ~misalign_q;
`else
  assign wb_valid = valid_q & ~is_store_q;
`endif
  assign wb_idx = idx_q;
  assign wb_val = is_load_q ? ld_val : val_q;

  assign wb_en_valid = in_send & nextPipReadyToRcv;
  assign wb_en_idx   = in_send & nextPipReadyToRcv;
  assign wb_en_data  = in_send & nextPipReadyToRcv;

  logic fwd;
  assign fwd    = in_send & wb_valid & (idx_q != '0);
  assign bp_idx = fwd ? idx_q : '0;
  assign bp_val = fwd ? wb_val : '0;

endmodule

// File: tb/tb_memory_access.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_memory_access
// Directed self-checking bench for memory_access. Inputs change and outputs
// are sampled 1ns after the rising edge; each scenario task does its own
// comparisons against hand-computed values.
// -----------------------------------------------------------------------------
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        startSig;
  logic        beforePipReadyToSend;
  logic        nextPipReadyToRcv;
  logic        ex_valid;
  logic [4:0]  ex_idx;
  logic [31:0] ex_val;
  logic [31:0] ex_store_data;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic        curPipReadyToRcv;
  logic        curPipReadyToSend;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic [31:0] wb_val;
  logic        wb_en_valid;
  logic        wb_en_idx;
  logic        wb_en_data;
  logic [4:0]  bp_idx;
  logic [31:0] bp_val;
  logic        misalign;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] got, want;

  memory_access_if #(.XLEN(32)) dmem_bus ();

  memory_access #(.XLEN(32), .REG_IDX(5)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .startSig             (startSig),
    .beforePipReadyToSend (beforePipReadyToSend),
    .nextPipReadyToRcv    (nextPipReadyToRcv),
    .ex_valid             (ex_valid),
    .ex_idx               (ex_idx),
    .ex_val               (ex_val),
    .ex_store_data        (ex_store_data),
    .ex_is_load           (ex_is_load),
    .ex_is_store          (ex_is_store),
    .ex_funct3            (ex_funct3),
    .curPipReadyToRcv     (curPipReadyToRcv),
    .curPipReadyToSend    (curPipReadyToSend),
    .wb_valid             (wb_valid),
    .wb_idx               (wb_idx),
    .wb_val               (wb_val),
    .wb_en_valid          (wb_en_valid),
    .wb_en_idx            (wb_en_idx),
    .wb_en_data           (wb_en_data),
    .bp_idx               (bp_idx),
    .bp_val               (bp_val),
    .dmem                 (dmem_bus),
    .misalign             (misalign)
  );

  always #5 clk = ~clk;

  // Formatting vectors: store flag, funct3, address, store data, memory word,
  // expected word address, expected wb_val (load) or wdata (store), strobes.
  typedef struct packed {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_val;
    logic [3:0]  exp_strb;
  } fmt_vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [4:0] idx, input logic [31:0] val,
                         input logic [31:0] sdata, input logic ld, input logic st,
                         input logic [2:0] f3);
    ex_valid             = v;
    ex_idx               = idx;
    ex_val               = val;
    ex_store_data        = sdata;
    ex_is_load           = ld;
    ex_is_store          = st;
    ex_funct3            = f3;
    beforePipReadyToSend = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    startSig = 1'b0; beforePipReadyToSend = 1'b0; nextPipReadyToRcv = 1'b0;
    present(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000);
    beforePipReadyToSend = 1'b0;
    dmem_bus.ack = 1'b0; dmem_bus.rdata = 32'h0;
    repeat (2) tick;
    got  = {curPipReadyToRcv, curPipReadyToSend, wb_valid, wb_idx, wb_val,
            wb_en_valid, wb_en_idx, wb_en_data, bp_idx, bp_val, misalign};
    want = '0;
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL reset_pipe: got %h want %h", got, want); end
    got  = {dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, dmem_bus.wstrb};
    want = '0;
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL reset_bus: got %h want %h", got, want); end

    rst = 1'b0;
    nextPipReadyToRcv = 1'b1;
    beforePipReadyToSend = 1'b1;
    tick;
    got  = {curPipReadyToRcv, curPipReadyToSend, dmem_bus.req};
    want = 3'b000;
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL idle_ignores_before: got %h want %h", got, want); end

    beforePipReadyToSend = 1'b0;
    startSig = 1'b1;
    tick;
    startSig = 1'b0;
    #1;
    got  = {curPipReadyToRcv, curPipReadyToSend};
    want = 2'b10;
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL start_to_wait: got %h want %h", got, want); end
  endtask

  task automatic test_pass_through;
    present(1'b1, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 3'b000);
    tick;
    beforePipReadyToSend = 1'b0;
    #1;
    got  = {curPipReadyToSend, wb_valid, wb_idx, wb_val, wb_en_valid, wb_en_idx, wb_en_data,
            bp_idx, bp_val, dmem_bus.req};
    want = {1'b1, 1'b1, 5'd5, 32'h1234, 1'b1, 1'b1, 1'b1, 5'd5, 32'h1234, 1'b0};
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL pass_sending: got %h want %h", got, want); end
    tick;
    got  = {curPipReadyToSend, wb_en_valid, bp_idx, bp_val, curPipReadyToRcv};
    want = {1'b0, 1'b0, 5'd0, 32'h0, 1'b1};
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL pass_back_to_wait: got %h want %h", got, want); end
  endtask

  task automatic test_load_byte;
    present(1'b1, 5'd7, 32'h103, 32'h0, 1'b1, 1'b0, 3'b000);
    tick;
    beforePipReadyToSend = 1'b0;
    #1;
    got  = {dmem_bus.req, dmem_bus.we, dmem_bus.addr, curPipReadyToSend};
    want = {1'b1, 1'b0, 32'h100, 1'b0};
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL lb_request: got %h want %h", got, want); end
    tick;
    tick;
    dmem_bus.rdata = 32'h80FF_FF00;
    dmem_bus.ack   = 1'b1;
    #1;
    got  = {dmem_bus.req, dmem_bus.addr, curPipReadyToSend};
    want = {1'b1, 32'h100, 1'b0};
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL lb_req_held: got %h want %h", got, want); end
    tick;
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 32'h0;
    #1;
    got  = {curPipReadyToSend, wb_valid, wb_idx, wb_val, bp_val, dmem_bus.req};
    want = {1'b1, 1'b1, 5'd7, 32'hFFFF_FF80, 32'hFFFF_FF80, 1'b0};
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL lb_result: got %h want %h", got, want); end
    tick;
  endtask

  task automatic test_store_half;
    present(1'b1, 5'd9, 32'h22, 32'h1234_ABCD, 1'b0, 1'b1, 3'b001);
    tick;
    beforePipReadyToSend = 1'b0;
    dmem_bus.ack = 1'b1;
    #1;
    got  = {dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, dmem_bus.wstrb};
    want = {1'b1, 1'b1, 32'h20, 32'hABCD_ABCD, 4'b1100};
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL sh_bus: got %h want %h", got, want); end
    tick;
    dmem_bus.ack = 1'b0;
    #1;
    got  = {curPipReadyToSend, wb_valid, bp_idx, bp_val, wb_en_valid, dmem_bus.req};
    want = {1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0};
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL sh_sending: got %h want %h", got, want); end
    tick;
  endtask

  task automatic test_formatting;
    fmt_vec_t vecs [7];
    vecs[0] = '{1'b0, 3'b001, 32'h102, 32'h0,         32'h8001_7F00, 32'h100, 32'hFFFF_8001, 4'h0};
    vecs[1] = '{1'b0, 3'b101, 32'h102, 32'h0,         32'h8001_7F00, 32'h100, 32'h0000_8001, 4'h0};
    vecs[2] = '{1'b0, 3'b100, 32'h101, 32'h0,         32'h8001_7F00, 32'h100, 32'h0000_007F, 4'h0};
    vecs[3] = '{1'b0, 3'b000, 32'h100, 32'h0,         32'h0000_00F0, 32'h100, 32'hFFFF_FFF0, 4'h0};
    vecs[4] = '{1'b0, 3'b010, 32'h208, 32'h0,         32'hCAFE_F00D, 32'h208, 32'hCAFE_F00D, 4'h0};
    vecs[5] = '{1'b1, 3'b000, 32'h101, 32'h1234_565A, 32'h0,         32'h100, 32'h5A5A_5A5A, 4'b0010};
    vecs[6] = '{1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0,         32'h104, 32'hDEAD_BEEF, 4'b1111};
    for (int i = 0; i < 7; i++) begin
      present(1'b1, 5'd10, vecs[i].addr, vecs[i].sdata, ~vecs[i].st, vecs[i].st, vecs[i].f3);
      tick;
      beforePipReadyToSend = 1'b0;
      dmem_bus.rdata = vecs[i].rdata;
      dmem_bus.ack   = 1'b1;
      #1;
      if (vecs[i].st) begin
        got  = {dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, dmem_bus.wstrb};
        want = {1'b1, vecs[i].exp_addr, vecs[i].exp_val, vecs[i].exp_strb};
      end else begin
        got  = {dmem_bus.we, dmem_bus.addr};
        want = {1'b0, vecs[i].exp_addr};
      end
      n_cmp++;
      if (got !== want) begin n_err++; $display("[TB] FAIL fmt_bus[%0d]: got %h want %h", i, got, want); end
      tick;
      dmem_bus.ack   = 1'b0;
      dmem_bus.rdata = 32'h0;
      #1;
      if (!vecs[i].st) begin
        n_cmp++;
        if (wb_val !== vecs[i].exp_val) begin
          n_err++; $display("[TB] FAIL fmt_load[%0d]: got %h want %h", i, wb_val, vecs[i].exp_val);
        end
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    nextPipReadyToRcv = 1'b0;
    present(1'b1, 5'd3, 32'hCAFE, 32'h0, 1'b0, 1'b0, 3'b000);
    tick;
    present(1'b1, 5'd4, 32'h1111, 32'h0, 1'b0, 1'b0, 3'b000);
    for (int c = 0; c < 3; c++) begin
      #1;
      got  = {curPipReadyToSend, curPipReadyToRcv, wb_en_valid, wb_en_idx, wb_en_data,
              wb_idx, wb_val, bp_idx};
      want = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'hCAFE, 5'd3};
      n_cmp++;
      if (got !== want) begin n_err++; $display("[TB] FAIL backpressure[%0d]: got %h want %h", c, got, want); end
      tick;
    end
    nextPipReadyToRcv = 1'b1;
    #1;
    got  = {wb_en_valid, curPipReadyToRcv, wb_val};
    want = {1'b1, 1'b1, 32'hCAFE};
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL release: got %h want %h", got, want); end
    tick;
    present(1'b1, 5'd6, 32'h2222, 32'h0, 1'b0, 1'b0, 3'b000);
    #1;
    got  = {curPipReadyToSend, wb_idx, wb_val, wb_en_valid};
    want = {1'b1, 5'd4, 32'h1111, 1'b1};
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL b2b_first: got %h want %h", got, want); end
    tick;
    beforePipReadyToSend = 1'b0;
    #1;
    got  = {curPipReadyToSend, wb_idx, wb_val};
    want = {1'b1, 5'd6, 32'h2222};
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL b2b_second: got %h want %h", got, want); end
    tick;
    n_cmp++;
    if (curPipReadyToSend !== 1'b0) begin
      n_err++; $display("[TB] FAIL b2b_drain: got %h want %h", curPipReadyToSend, 1'b0);
    end
  endtask

  task automatic test_ack_ignored;
    dmem_bus.ack = 1'b1;
    tick;
    dmem_bus.ack = 1'b0;
    got  = {curPipReadyToSend, dmem_bus.req, curPipReadyToRcv};
    want = 3'b001;
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL stray_ack: got %h want %h", got, want); end
  endtask

  task automatic test_misalign;
    present(1'b1, 5'd11, 32'h101, 32'h0, 1'b1, 1'b0, 3'b010);
    tick;
    beforePipReadyToSend = 1'b0;
    #1;
`ifdef MEM_MISALIGN_CHECK_EN
    got  = {dmem_bus.req, misalign, curPipReadyToSend, wb_valid};
    want = 4'b0110;
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL misalign_lw: got %h want %h", got, want); end
    tick;
    n_cmp++;
    if (misalign !== 1'b0) begin n_err++; $display("[TB] FAIL misalign_clear: got %h want %h", misalign, 1'b0); end
`else
    got  = {dmem_bus.req, dmem_bus.addr, misalign};
    want = {1'b1, 32'h100, 1'b0};
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL aligned_down_req: got %h want %h", got, want); end
    dmem_bus.rdata = 32'hDEAD_BEEF;
    dmem_bus.ack   = 1'b1;
    tick;
    dmem_bus.ack   = 1'b0;
    #1;
    got  = {curPipReadyToSend, wb_valid, wb_val, misalign};
    want = {1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0};
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL aligned_down_load: got %h want %h", got, want); end
    tick;
`endif
  endtask

  task automatic test_reset_mid_req;
    present(1'b1, 5'd12, 32'h40, 32'h0, 1'b1, 1'b0, 3'b010);
    tick;
    beforePipReadyToSend = 1'b0;
    tick;
    n_cmp++;
    if (dmem_bus.req !== 1'b1) begin n_err++; $display("[TB] FAIL rst_pre_req: got %h want %h", dmem_bus.req, 1'b1); end
    rst = 1'b1;
    #1;
    got  = {dmem_bus.req, dmem_bus.we, dmem_bus.addr};
    want = '0;
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL rst_drops_req: got %h want %h", got, want); end
    tick;
    rst = 1'b0;
    dmem_bus.rdata = 32'h5555_AAAA;
    dmem_bus.ack   = 1'b1;
    tick;
    dmem_bus.ack   = 1'b0;
    #1;
    got  = {dmem_bus.req, curPipReadyToSend, curPipReadyToRcv, wb_valid, wb_val};
    want = '0;
    n_cmp++;
    if (got !== want) begin n_err++; $display("[TB] FAIL late_ack: got %h want %h", got, want); end
  endtask

  initial begin
    $display("[TB] memory_access directed bench");
    test_reset;
    test_pass_through;
    test_load_byte;
    test_store_half;
    test_formatting;
    test_back_to_back;
    test_ack_ignored;
    test_misalign;
    test_reset_mid_req;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
